// File: rtl/echo_detector.sv
// Sonar echo detector: after a trigger, skip a blanking window, then report the first
// run of min_hits consecutive over-threshold samples (index + peak) or a timeout.
module echo_detector #(
    parameter int N     = 16,
    parameter int CNT_W = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               en_i,
    input  logic               start_i,
    input  logic               valid_i,
    input  logic [2*N-1:0]     data_i,
    input  logic [2*N-1:0]     thr_i,
    input  logic [3:0]         min_hits_i,
    input  logic [CNT_W-1:0]   blank_i,
    input  logic [CNT_W-1:0]   timeout_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               echo_o,
    output logic [CNT_W-1:0]   tof_o,
    output logic [2*N-1:0]     peak_o,
    output logic               irq_o
);
    localparam int W = 2 * N;
    localparam logic [W-1:0]     W_ONE   = 1;
    localparam logic [CNT_W-1:0] C_ONE   = 1;
    localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]     MOST_POS = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, BLANK, LISTEN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [3:0]       hits_q, hits_d;
    logic [CNT_W-1:0] tof_q, tof_d;
    logic [W-1:0]     peak_q, peak_d;
    logic             echo_q, echo_d;
    logic             done_q, done_d;
    logic             irq_q, irq_d;

    logic [W-1:0]     mag;
    logic             hit;
    logic [3:0]       need;
    logic [3:0]       hits_inc;
    logic [CNT_W-1:0] cnt_inc;
    logic             to_hit;
    logic             blank_end;

    // Magnitude saturates so the most negative sample still fits in W-1 bits.
    always_comb begin
        if (!data_i[W-1])          mag = data_i;
        else if (data_i == MOST_NEG) mag = MOST_POS;
        else                       mag = ~data_i + W_ONE;
    end

    assign hit       = mag > thr_i;
    assign need      = (min_hits_i == 4'd0) ? 4'd1 : min_hits_i;
    assign hits_inc  = (hits_q == 4'hF) ? 4'hF : hits_q + 4'd1;
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + C_ONE;
    assign to_hit    = (timeout_i != '0) && (cnt_q == timeout_i - C_ONE);
    assign blank_end = (cnt_q == blank_i - C_ONE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            run_q   <= '0;
            hits_q  <= '0;
            tof_q   <= '0;
            peak_q  <= '0;
            echo_q  <= 1'b0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            hits_q  <= hits_d;
            tof_q   <= tof_d;
            peak_q  <= peak_d;
            echo_q  <= echo_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        hits_d  = hits_q;
        tof_d   = tof_q;
        peak_d  = peak_q;
        echo_d  = echo_q;
        done_d  = done_q;
        irq_d   = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
        end else if (start_i) begin
            // A sample coinciding with start is dropped on purpose.
            cnt_d   = '0;
            run_d   = '0;
            hits_d  = '0;
            tof_d   = '0;
            peak_d  = '0;
            echo_d  = 1'b0;
            done_d  = 1'b0;
            state_d = (blank_i == '0) ? LISTEN : BLANK;
        end else if (valid_i) begin
            case (state_q)
                BLANK: begin
                    cnt_d = cnt_inc;
                    if (to_hit) begin
                        state_d = DONE;
                        echo_d  = 1'b0;
                        tof_d   = '1;
                        done_d  = 1'b1;
                        irq_d   = 1'b1;
                    end else if (blank_end) begin
                        state_d = LISTEN;
                    end
                end
                LISTEN: begin
                    cnt_d = cnt_inc;
                    if (mag > peak_q) peak_d = mag;
                    if (hit) begin
                        hits_d = hits_inc;
                        if (hits_q == 4'd0) run_d = cnt_q;
                    end else begin
                        hits_d = 4'd0;
                    end
                    // Detection outranks a timeout landing on the same sample.
                    if (hit && (hits_inc >= need)) begin
                        state_d = DONE;
                        echo_d  = 1'b1;
                        tof_d   = (hits_q == 4'd0) ? cnt_q : run_q;
                        done_d  = 1'b1;
                        irq_d   = 1'b1;
                    end else if (to_hit) begin
                        state_d = DONE;
                        echo_d  = 1'b0;
                        tof_d   = '1;
                        done_d  = 1'b1;
                        irq_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state_q == BLANK) || (state_q == LISTEN);
    assign done_o = done_q;
    assign echo_o = echo_q;
    assign tof_o  = tof_q;
    assign peak_o = peak_q;
    assign irq_o  = irq_q;
endmodule

// File: tb/tb_echo_detector.sv
// Scoreboard bench for echo_detector: each measurement's outcome is derived from the
// sample list by run search, and a monitor checks it on every irq_o.
module tb_echo_detector;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i, en_i, start_i, valid_i;
    logic [31:0] data_i, thr_i;
    logic [3:0]  min_hits_i;
    logic [15:0] blank_i, timeout_i;
    logic        busy_o, done_o, echo_o, irq_o;
    logic [15:0] tof_o;
    logic [31:0] peak_o;

    always #5 wb_clk_i = ~wb_clk_i;

    echo_detector #(.N(16), .CNT_W(16)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .en_i(en_i), .start_i(start_i),
        .valid_i(valid_i), .data_i(data_i), .thr_i(thr_i), .min_hits_i(min_hits_i),
        .blank_i(blank_i), .timeout_i(timeout_i), .busy_o(busy_o), .done_o(done_o),
        .echo_o(echo_o), .tof_o(tof_o), .peak_o(peak_o), .irq_o(irq_o)
    );

    typedef struct {
        int          end_idx;
        logic        echo;
        logic [15:0] tof;
        logic [31:0] peak;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          drv_idx = -1;
    logic [31:0] s_data[64];
    int          s_gap[64];
    int          s_n;
    logic        co_valid;
    logic [31:0] co_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] magf(input logic [31:0] d);
        if (d == 32'h8000_0000) return 32'h7FFF_FFFF;
        if (d[31]) return -d;
        return d;
    endfunction

    // Outcome = earliest end of a full run of `need` hits inside the listen window,
    // unless the timeout sample comes first.
    task automatic model_push();
        int          need, det_end, to_end;
        bit          all;
        exp_t        x;
        logic [31:0] pk;
        need    = (min_hits_i == 0) ? 1 : int'(min_hits_i);
        det_end = -1;
        for (int k = int'(blank_i) + need - 1; k < s_n && det_end < 0; k++) begin
            all = 1;
            for (int j = k - need + 1; j <= k; j++)
                if (!(magf(s_data[j]) > thr_i)) all = 0;
            if (all) det_end = k;
        end
        to_end = (timeout_i != 0) ? int'(timeout_i) - 1 : -1;
        if (det_end >= 0 && (to_end < 0 || det_end <= to_end)) begin
            x.end_idx = det_end; x.echo = 1'b1; x.tof = 16'(det_end - need + 1);
        end else if (to_end >= 0 && to_end < s_n) begin
            x.end_idx = to_end; x.echo = 1'b0; x.tof = 16'hFFFF;
        end else begin
            return;
        end
        pk = 0;
        for (int j = int'(blank_i); j <= x.end_idx; j++)
            if (magf(s_data[j]) > pk) pk = magf(s_data[j]);
        x.peak = pk;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic clr(input int n);
        s_n = n;
        for (int i = 0; i < 64; i++) begin
            s_data[i] = 0;
            s_gap[i]  = 0;
        end
    endtask

    task automatic drive_meas();
        model_push();
        drv_idx = -1;
        start_i = 1'b1; valid_i = co_valid; data_i = co_data;
        tick();
        start_i = 1'b0; valid_i = 1'b0; co_valid = 1'b0;
        chk("busy_after_start", busy_o, 1);
        chk("done_after_start", done_o, 0);
        for (int i = 0; i < s_n; i++) begin
            repeat (s_gap[i]) tick();
            drv_idx = i; data_i = s_data[i]; valid_i = 1'b1;
            tick();
            valid_i = 1'b0;
        end
        repeat (3) tick();
        chk("expected_irq_seen", sb.size(), 0);
    endtask

    function automatic logic [31:0] rnd_smp();
        case ($urandom_range(0, 9))
            0:       return 32'h8000_0000;
            1:       return $urandom;
            2, 3, 4: return 32'(-$urandom_range(0, 4000));
            default: return $urandom_range(0, 4000);
        endcase
    endfunction

    task automatic cfg(input int bl, input int th, input int mh, input int to);
        blank_i = 16'(bl); thr_i = 32'(th); min_hits_i = 4'(mh); timeout_i = 16'(to);
    endtask

    // Monitor: every irq_o must match the oldest outstanding expectation.
    initial begin
        exp_t x;
        int   e_idx;
        logic e_vld;
        forever begin
            @(posedge wb_clk_i);
            e_idx = drv_idx;
            e_vld = valid_i;
            @(negedge wb_clk_i);
            if (irq_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_irq", irq_o, 0);
                end else begin
                    x = sb.pop_front();
                    chk("irq_on_valid", e_vld, 1);
                    chk("irq_sample_idx", 64'(e_idx), 64'(x.end_idx));
                    chk("done", done_o, 1);
                    chk("echo", echo_o, x.echo);
                    chk("tof", tof_o, x.tof);
                    chk("peak", peak_o, x.peak);
                    chk("busy_at_done", busy_o, 0);
                end
            end
        end
    end

    initial begin
        wb_rst_i = 1'b1; en_i = 1'b1; start_i = 1'b0; valid_i = 1'b0; data_i = 0;
        co_valid = 1'b0; co_data = 0;
        cfg(0, 1000, 1, 0);
        tick(); tick();
        chk("reset_outputs", {busy_o, done_o, echo_o, irq_o, tof_o, peak_o}, 0);
        wb_rst_i = 1'b0;
        tick();

        // Basic echo
        cfg(4, 1000, 2, 100); clr(12);
        for (int i = 0; i < 4; i++) s_data[i] = 5000;
        s_data[10] = 1500; s_data[11] = 32'hFFFF_F830;
        drive_meas();

        // Glitch rejection with valid gaps inside the run
        cfg(0, 1000, 3, 0); clr(25);
        s_data[5] = 3000; s_data[20] = 3000; s_data[21] = 32'hFFFF_F448; s_data[22] = 3000;
        s_gap[21] = 3; s_gap[22] = 3;
        drive_meas();

        // Timeout, then a one-hit detection on the timeout sample
        cfg(2, 1000, 2, 8); clr(10);
        drive_meas();
        cfg(2, 1000, 1, 8); clr(10);
        s_data[7] = 3000;
        drive_meas();

        // Most negative sample saturates
        cfg(0, 32'h7FFF_FFFE, 0, 0); clr(1);
        s_data[0] = 32'h8000_0000;
        drive_meas();

        // Restart mid-LISTEN; the sample coinciding with start is discarded
        cfg(0, 1000, 2, 0); clr(3);
        drive_meas();
        clr(3);
        s_data[1] = 5000; s_data[2] = 5000;
        co_valid = 1'b1; co_data = 5000;
        drive_meas();

        // Enable low: DONE values held, then LISTEN values held, start ignored
        cfg(0, 1000, 1, 0); clr(1);
        s_data[0] = 3000;
        drive_meas();
        en_i = 1'b0; tick();
        chk("enlow_done_hold", {done_o, echo_o, tof_o, peak_o}, {1'b1, 1'b1, 16'd0, 32'd3000});
        en_i = 1'b1; tick();
        clr(1);
        s_data[0] = 500;
        drive_meas();
        chk("peak_in_listen", peak_o, 500);
        en_i = 1'b0; tick();
        chk("enlow_busy", busy_o, 0);
        chk("enlow_hold", {done_o, echo_o, tof_o, peak_o}, {1'b0, 1'b0, 16'd0, 32'd500});
        start_i = 1'b1; valid_i = 1'b1; data_i = 3000; tick();
        start_i = 1'b0; tick(); valid_i = 1'b0;
        chk("enlow_start_ignored", {busy_o, done_o, peak_o}, {1'b0, 1'b0, 32'd500});
        en_i = 1'b1; valid_i = 1'b1; tick(); valid_i = 1'b0; tick();
        chk("idle_after_enlow", {busy_o, done_o, peak_o}, {1'b0, 1'b0, 32'd500});

        // Reset during LISTEN with one hit pending
        cfg(0, 1000, 3, 0); clr(1);
        s_data[0] = 2000;
        drive_meas();
        chk("peak_before_reset", peak_o, 2000);
        wb_rst_i = 1'b1; tick();
        chk("midrun_reset", {busy_o, done_o, echo_o, irq_o, tof_o, peak_o}, 0);
        wb_rst_i = 1'b0;
        data_i = 2000; valid_i = 1'b1; tick(); tick(); valid_i = 1'b0; tick();
        chk("idle_after_reset", {busy_o, done_o, irq_o, peak_o}, 0);

        // Randomized measurements
        for (int it = 0; it < 40; it++) begin
            cfg($urandom_range(0, 4), $urandom_range(500, 3000), $urandom_range(0, 4),
                ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30));
            clr(30);
            for (int i = 0; i < 30; i++) begin
                s_data[i] = rnd_smp();
                s_gap[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end
            drive_meas();
        end

        repeat (4) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/echo_detector.md
# echo_detector

Time-of-flight echo detector for the sonar receive chain. It sits directly downstream of the constant-gain multiplier and consumes its 2N-bit amplified sample stream. After a transmit trigger it ignores a programmable blanking window, then searches for the first run of consecutive samples whose magnitude exceeds a threshold. It reports the echo sample index, the peak magnitude and a one-cycle interrupt; if no echo arrives before the timeout, it reports a timeout instead.

## Interface
- N, 16: base width; sample and threshold are 2N bits.
- CNT_W, 16: width of the sample-index counter, blank, timeout and tof_o.
- wb_clk_i  in  1  single clock; all logic rising-edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  block enable; low forces IDLE next cycle.
- start_i  in  1  one-cycle trigger; begins a measurement.
- valid_i  in  1  sample strobe for data_i.
- data_i  in  2N  signed two's-complement amplified sample.
- thr_i  in  2N  unsigned magnitude threshold.
- min_hits_i  in  4  required consecutive hits; 0 is treated as 1.
- blank_i  in  CNT_W  number of leading samples ignored.
- timeout_i  in  CNT_W  sample limit; 0 means no timeout.
- busy_o  out  1  high in BLANK or LISTEN.
- done_o  out  1  measurement finished; stays high until the next start or reset.
- echo_o  out  1  1 means an echo was found, 0 means a timeout.
- tof_o  out  CNT_W  sample index of the first hit of the qualifying run.
- peak_o  out  2N  maximum magnitude seen in LISTEN up to completion.
- irq_o  out  1  one-cycle completion pulse.

## Operation
- **States:** IDLE, BLANK, LISTEN, DONE.
- **Reset:** state IDLE. All outputs 0. Internal counters 0.
- **Start:** start_i with en_i=1, in any state:
  - Clear cnt, hits, peak_o, tof_o, echo_o and done_o.
  - Next state is BLANK, or LISTEN if blank_i=0.
  - If start_i and valid_i coincide, start wins and the sample is discarded.
- **Sample index (cnt):** the first valid sample after start has index 0. cnt increments once per valid_i in BLANK/LISTEN and saturates at all-ones.
- **BLANK:**
  - Samples are counted but not evaluated.
  - After the sample with index blank_i-1, the next state is LISTEN.
- **Magnitude:** mag = |data_i|. The value 0x8000_0000 (N=16) saturates to 0x7FFF_FFFF.
- **Hit:** mag > thr_i (strict).
- **LISTEN, per valid sample:**
  - peak_o = max(peak_o, mag).
  - On a hit: hits increments, saturating at 15. If hits was 0, record the run-start index = cnt.
  - On a non-hit: hits is cleared.
- **Detection:** the updated hits reaches max(min_hits_i,1). Then:
  - State DONE, echo_o=1, tof_o = run-start index, done_o=1, irq_o pulse.
- **Timeout:** timeout_i≠0, a sample with index timeout_i-1 is processed in BLANK or LISTEN, and it does not complete a detection. Then:
  - State DONE, echo_o=0, tof_o = all-ones, done_o=1, irq_o pulse.
  - Detection has priority over timeout on the same sample.
- **DONE:** outputs hold. Samples are ignored. Only start_i (or en_i low) leaves DONE.
- **en_i low:**
  - State IDLE next cycle and busy_o=0.
  - done_o, echo_o, tof_o and peak_o hold.
  - start_i is ignored while en_i=0.
- **Config inputs:** thr_i, min_hits_i, blank_i and timeout_i are sampled live. Software keeps them stable during BLANK/LISTEN.

## Timing
- start_i at edge t: busy_o=1 and done_o=0 are visible after edge t.
- Sample completing a detection or timeout, registered at edge t:
  - done_o, echo_o, tof_o and peak_o are valid after edge t.
  - irq_o is high for exactly that one cycle.
  - busy_o=0 in the same cycle.
- peak_o updates one cycle after each LISTEN sample.
- valid_i may be asserted every cycle or with arbitrary gaps. Gaps do not advance cnt and do not reset hits.
- wb_rst_i mid-measurement: state IDLE and all outputs 0 on the next edge. No irq_o is generated.
- start_i during BLANK/LISTEN restarts cleanly with no irq_o.

## Test plan
1. **Reset:** assert wb_rst_i during LISTEN with hits=1 -> next cycle all outputs 0, state IDLE, no irq_o.
2. **Basic echo:**
   - Config: blank=4, thr=1000, min_hits=2, timeout=100.
   - Samples: 5000 at idx 0–3, 0 at idx 4–9, 1500 at idx 10, -2000 at idx 11.
   - Required: done_o=1, echo_o=1, tof_o=10, peak_o=2000, irq_o one cycle, all after edge of idx 11.
3. **Glitch rejection:**
   - Config: min_hits=3, blank=0.
   - Samples: single hit at idx 5; hits at idx 20, 21, 22 with 3-cycle valid gaps between them.
   - Required: tof_o=20, detection on idx 22.
4. **Timeout:**
   - Config: timeout=8, blank=2, all samples 0.
   - Required: completion on idx 7, echo_o=0, tof_o=0xFFFF, peak_o=0, single irq_o.
   - Companion case: a 1-hit detection on idx 7 with min_hits=1 -> echo_o=1, tof_o=7.
5. **Magnitude saturation:** data_i=0x8000_0000, thr=0x7FFF_FFFE, min_hits=0 -> detection on that sample, peak_o=0x7FFF_FFFF.
6. **Restart/enable:**
   - start_i at idx 3 of LISTEN -> cnt restarts; next valid is idx 0.
   - start_i together with valid_i -> that sample is discarded.
   - en_i low in LISTEN -> busy_o=0 next cycle, no irq_o, previous done/tof values held.
